// File: rtl/regfile_wb_scheduler_if.sv
// regfile_wb_scheduler_if: issue, ALU/MEM writeback and register-file write port bundle
interface regfile_wb_scheduler_if #(
  parameter int IDXW  = 5,
  parameter int DATAW = 32
);
  logic             iss_valid;
  logic             iss_ready;
  logic [IDXW-1:0]  iss_rs1;
  logic [IDXW-1:0]  iss_rs2;
  logic [IDXW-1:0]  iss_rd;
  logic             iss_rd_we;
  logic             alu_valid;
  logic             alu_ready;
  logic [IDXW-1:0]  alu_idx;
  logic [DATAW-1:0] alu_data;
  logic             mem_valid;
  logic             mem_ready;
  logic [IDXW-1:0]  mem_idx;
  logic [DATAW-1:0] mem_data;
  logic             wr_en;
  logic [IDXW-1:0]  wr_idx;
  logic [DATAW-1:0] wr_data;
  logic [IDXW:0]    busy_count;
  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_we,
    output alu_valid, alu_idx, alu_data, mem_valid, mem_idx, mem_data,
    input  iss_ready, alu_ready, mem_ready, wr_en, wr_idx, wr_data, busy_count
  );
  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_we,
    input  alu_valid, alu_idx, alu_data, mem_valid, mem_idx, mem_data,
    output iss_ready, alu_ready, mem_ready, wr_en, wr_idx, wr_data, busy_count
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: busy-bit scoreboard with round-robin ALU/MEM arbitration onto the register-file write port
module regfile_wb_scheduler #(
  parameter int NREG  = 32,
  parameter int IDXW  = 5,
  parameter int DATAW = 32
) (
  input logic clk,
  input logic reset_n,
  regfile_wb_scheduler_if.slave bus
);
  typedef enum logic {ALU, MEM} grantT;
  grantT            lastGrant;
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busyNext;
  logic [IDXW:0]    countNext;
  logic             issReady;
  logic             issFire;
  logic             grantAlu;
  logic             grantMem;
  logic             grantAny;
  logic [IDXW-1:0]  grantIdx;
  logic [DATAW-1:0] grantData;
  logic             doWrite;
  // hazard check against registered busy bits only; x0 never busy so it never stalls
  always_comb begin
    issReady = !busy[bus.iss_rs1] && !busy[bus.iss_rs2] && !(bus.iss_rd_we && busy[bus.iss_rd]);
    issFire  = bus.iss_valid && issReady && bus.iss_rd_we && (bus.iss_rd != '0);
  end
  assign bus.iss_ready = issReady;
  // round-robin: a lone requester wins, on contention the one not granted last time wins
  always_comb begin
    grantAlu  = bus.alu_valid && (!bus.mem_valid || lastGrant == MEM);
    grantMem  = bus.mem_valid && (!bus.alu_valid || lastGrant == ALU);
    grantAny  = grantAlu || grantMem;
    grantIdx  = grantAlu ? bus.alu_idx : bus.mem_idx;
    grantData = grantAlu ? bus.alu_data : bus.mem_data;
    doWrite   = grantAny && (grantIdx != '0);
  end
  assign bus.alu_ready = grantAlu;
  assign bus.mem_ready = grantMem;
  // next busy vector: landing write clears, issue sets afterwards so a same-index set wins
  always_comb begin
    busyNext = busy;
    if (bus.wr_en) busyNext[bus.wr_idx] = 1'b0;
    if (issFire) busyNext[bus.iss_rd] = 1'b1;
    busyNext[0] = 1'b0;
    countNext = '0;
    for (int i = 0; i < NREG; i++) countNext = countNext + {{IDXW{1'b0}}, busyNext[i]};
  end
  // scoreboard, arbitration history and registered write port; reset drops any in-flight write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy           <= '0;
      lastGrant      <= MEM;
      bus.wr_en      <= 1'b0;
      bus.wr_idx     <= '0;
      bus.wr_data    <= '0;
      bus.busy_count <= '0;
    end else begin
      busy           <= busyNext;
      bus.busy_count <= countNext;
      bus.wr_en      <= doWrite;
      if (doWrite) begin
        bus.wr_idx  <= grantIdx;
        bus.wr_data <= grantData;
      end
      if (grantAny) lastGrant <= grantAlu ? ALU : MEM;
    end
  end
endmodule
